// File: rtl/rob_ctrl_if.sv
// Issue, CDB writeback, operand-query and retire signals between the core and
// the reorder-buffer controller.
interface rob_ctrl_if #(parameter int ROB_BIT = 5);
  logic               issue_valid;
  logic [1:0]         issue_type;
  logic [4:0]         issue_rd;
  logic               issue_pred_taken;
  logic               issue_ready;
  logic [31:0]        issue_val;
  logic               rob_full;
  logic [ROB_BIT-1:0] issue_entry;
  logic [4:0]         rf_issue_reg_id;
  logic [ROB_BIT-1:0] rf_issue_rob_entry;
  logic               cdb_valid;
  logic [ROB_BIT-1:0] cdb_entry;
  logic [31:0]        cdb_val;
  logic               cdb_taken;
  logic [31:0]        cdb_target;
  logic [ROB_BIT-1:0] qry_entry1;
  logic [ROB_BIT-1:0] qry_entry2;
  logic               qry_ready1;
  logic               qry_ready2;
  logic [31:0]        qry_val1;
  logic [31:0]        qry_val2;
  logic [4:0]         rf_commit_reg_id;
  logic [31:0]        rf_commit_data;
  logic [ROB_BIT-1:0] rf_commit_rob_entry;
  logic               store_commit;
  logic [ROB_BIT-1:0] store_commit_entry;
  logic               rob_clear_up;
  logic [31:0]        redirect_pc;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pred_taken, issue_ready, issue_val,
    output cdb_valid, cdb_entry, cdb_val, cdb_taken, cdb_target, qry_entry1, qry_entry2,
    input  rob_full, issue_entry, rf_issue_reg_id, rf_issue_rob_entry,
    input  qry_ready1, qry_ready2, qry_val1, qry_val2,
    input  rf_commit_reg_id, rf_commit_data, rf_commit_rob_entry,
    input  store_commit, store_commit_entry, rob_clear_up, redirect_pc
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pred_taken, issue_ready, issue_val,
    input  cdb_valid, cdb_entry, cdb_val, cdb_taken, cdb_target, qry_entry1, qry_entry2,
    output rob_full, issue_entry, rf_issue_reg_id, rf_issue_rob_entry,
    output qry_ready1, qry_ready2, qry_val1, qry_val2,
    output rf_commit_reg_id, rf_commit_data, rf_commit_rob_entry,
    output store_commit, store_commit_entry, rob_clear_up, redirect_pc
  );
endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order allocation and retirement, CDB capture,
// operand forwarding and the two-phase (commit, then clear) mispredict flush.
module rob_ctrl #(parameter int ROB_BIT = 5) (
  input logic       clk_in,
  input logic       rst_in,
  input logic       rdy_in,
  rob_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ROB_BIT;
  localparam logic [ROB_BIT:0] FULL_CNT = {1'b1, {ROB_BIT{1'b0}}};
  localparam logic [1:0] TYPE_STORE  = 2'd1;
  localparam logic [1:0] TYPE_BRANCH = 2'd2;

  typedef enum logic {ST_NORMAL = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ROB_BIT-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_BIT:0]   count_q, count_d;
  logic [DEPTH-1:0]   busy_q, busy_d, ready_q, ready_d;
  logic [DEPTH-1:0]   pred_q, pred_d, taken_q, taken_d;
  logic [1:0]         type_q [DEPTH];
  logic [1:0]         type_d [DEPTH];
  logic [4:0]         rd_q [DEPTH];
  logic [4:0]         rd_d [DEPTH];
  logic [31:0]        val_q [DEPTH];
  logic [31:0]        val_d [DEPTH];
  logic [31:0]        target_q [DEPTH];
  logic [31:0]        target_d [DEPTH];

  logic [4:0]         rf_commit_reg_id_q, rf_commit_reg_id_d;
  logic [31:0]        rf_commit_data_q, rf_commit_data_d;
  logic [ROB_BIT-1:0] rf_commit_rob_entry_q, rf_commit_rob_entry_d;
  logic               store_commit_q, store_commit_d;
  logic [ROB_BIT-1:0] store_commit_entry_q, store_commit_entry_d;
  logic               rob_clear_q, rob_clear_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;

  logic rob_full, issue_acc, commit_en, mispredict, cdb_hit1, cdb_hit2;

  // The clear pulse cycle also blocks issue so younger work restarts two cycles after the branch retires.
  assign rob_full   = (count_q == FULL_CNT) || (state_q == ST_FLUSH) || rob_clear_q;
  assign issue_acc  = rdy_in && bus.issue_valid && !rob_full;
  assign commit_en  = rdy_in && (state_q == ST_NORMAL) && busy_q[head_q] && ready_q[head_q];
  assign mispredict = commit_en && (type_q[head_q] == TYPE_BRANCH)
                      && (taken_q[head_q] != pred_q[head_q]);
  assign cdb_hit1   = bus.cdb_valid && (bus.cdb_entry == bus.qry_entry1);
  assign cdb_hit2   = bus.cdb_valid && (bus.cdb_entry == bus.qry_entry2);

  assign bus.rob_full           = rob_full;
  assign bus.issue_entry        = tail_q;
  assign bus.rf_issue_rob_entry = tail_q;
  assign bus.rf_issue_reg_id    = (issue_acc && (bus.issue_type != TYPE_STORE)) ? bus.issue_rd : 5'd0;
  assign bus.qry_ready1 = (busy_q[bus.qry_entry1] && ready_q[bus.qry_entry1]) || cdb_hit1;
  assign bus.qry_ready2 = (busy_q[bus.qry_entry2] && ready_q[bus.qry_entry2]) || cdb_hit2;
  assign bus.qry_val1   = cdb_hit1 ? bus.cdb_val : val_q[bus.qry_entry1];
  assign bus.qry_val2   = cdb_hit2 ? bus.cdb_val : val_q[bus.qry_entry2];

  assign bus.rf_commit_reg_id    = rf_commit_reg_id_q;
  assign bus.rf_commit_data      = rf_commit_data_q;
  assign bus.rf_commit_rob_entry = rf_commit_rob_entry_q;
  assign bus.store_commit        = store_commit_q;
  assign bus.store_commit_entry  = store_commit_entry_q;
  assign bus.rob_clear_up        = rob_clear_q;
  assign bus.redirect_pc         = redirect_pc_q;

  // Next-state: flush, or commit at head then CDB capture then allocation at tail.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    pred_d  = pred_q;
    taken_d = taken_q;
    type_d  = type_q;
    rd_d    = rd_q;
    val_d   = val_q;
    target_d = target_q;
    rf_commit_reg_id_d    = 5'd0;
    rf_commit_data_d      = rf_commit_data_q;
    rf_commit_rob_entry_d = rf_commit_rob_entry_q;
    store_commit_d        = 1'b0;
    store_commit_entry_d  = store_commit_entry_q;
    rob_clear_d           = 1'b0;
    redirect_pc_d         = redirect_pc_q;
    if (!rdy_in) begin
      state_d = state_q;
    end else if (state_q == ST_FLUSH) begin
      busy_d      = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      rob_clear_d = 1'b1;
      state_d     = ST_NORMAL;
    end else begin
      if (commit_en) begin
        busy_d[head_q]        = 1'b0;
        ready_d[head_q]       = 1'b0;
        head_d                = head_q + ROB_BIT'(1);
        rf_commit_data_d      = val_q[head_q];
        rf_commit_rob_entry_d = head_q;
        if (type_q[head_q] == TYPE_STORE) begin
          store_commit_d       = 1'b1;
          store_commit_entry_d = head_q;
        end else begin
          rf_commit_reg_id_d = rd_q[head_q];
        end
        if (mispredict) begin
          state_d       = ST_FLUSH;
          redirect_pc_d = target_q[head_q];
        end else begin
          state_d = ST_NORMAL;
        end
      end
      // busy_d so a writeback aimed at the entry retiring this edge is dropped.
      if (bus.cdb_valid && busy_d[bus.cdb_entry]) begin
        ready_d[bus.cdb_entry]  = 1'b1;
        val_d[bus.cdb_entry]    = bus.cdb_val;
        taken_d[bus.cdb_entry]  = bus.cdb_taken;
        target_d[bus.cdb_entry] = bus.cdb_target;
      end
      if (issue_acc) begin
        busy_d[tail_q]   = 1'b1;
        ready_d[tail_q]  = bus.issue_ready;
        type_d[tail_q]   = bus.issue_type;
        rd_d[tail_q]     = bus.issue_rd;
        val_d[tail_q]    = bus.issue_val;
        pred_d[tail_q]   = bus.issue_pred_taken;
        taken_d[tail_q]  = bus.issue_pred_taken;
        target_d[tail_q] = 32'd0;
        tail_d           = tail_q + ROB_BIT'(1);
      end
      count_d = count_q + (ROB_BIT+1)'(issue_acc) - (ROB_BIT+1)'(commit_en);
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q               <= ST_NORMAL;
      head_q                <= '0;
      tail_q                <= '0;
      count_q               <= '0;
      busy_q                <= '0;
      ready_q               <= '0;
      rf_commit_reg_id_q    <= 5'd0;
      rf_commit_data_q      <= 32'd0;
      rf_commit_rob_entry_q <= '0;
      store_commit_q        <= 1'b0;
      store_commit_entry_q  <= '0;
      rob_clear_q           <= 1'b0;
      redirect_pc_q         <= 32'd0;
    end else begin
      state_q               <= state_d;
      head_q                <= head_d;
      tail_q                <= tail_d;
      count_q               <= count_d;
      busy_q                <= busy_d;
      ready_q               <= ready_d;
      rf_commit_reg_id_q    <= rf_commit_reg_id_d;
      rf_commit_data_q      <= rf_commit_data_d;
      rf_commit_rob_entry_q <= rf_commit_rob_entry_d;
      store_commit_q        <= store_commit_d;
      store_commit_entry_q  <= store_commit_entry_d;
      rob_clear_q           <= rob_clear_d;
      redirect_pc_q         <= redirect_pc_d;
    end
  end

  // Entry payload; only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk_in) begin
    pred_q   <= pred_d;
    taken_q  <= taken_d;
    type_q   <= type_d;
    rd_q     <= rd_d;
    val_q    <= val_d;
    target_q <= target_d;
  end
endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: queue-based reference ROB predicts combinational outputs
// and retire/flush events; a negedge monitor pops and compares retire outputs.
module tb_rob_ctrl;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;

  rob_ctrl_if #(.ROB_BIT(5)) bus ();
  rob_ctrl #(.ROB_BIT(5)) dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  typedef struct {
    int tag; logic [1:0] typ; logic [4:0] rd; bit rdy;
    logic [31:0] val; bit pred; bit tkn; logic [31:0] tgt;
  } ent_t;
  typedef struct { bit st; logic [4:0] rd; logic [31:0] data; logic [4:0] tag; } cexp_t;

  ent_t        rob[$];
  cexp_t       exp_c[$];
  logic [31:0] exp_f[$];
  int tail = 0;
  bit flushing = 1'b0, clear_now = 1'b0, mon_en = 1'b0;
  int n_vec = 0, n_err = 0;

  bit          s_v, s_pt, s_ir, s_cv, s_ctk, s_rdy;
  logic [1:0]  s_t;
  logic [4:0]  s_rd, s_ce, s_q1, s_q2;
  logic [31:0] s_iv, s_cval, s_ctg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int find(input int tag);
    foreach (rob[i]) if (rob[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic clr();
    s_v = 1'b0; s_t = 2'd0; s_rd = 5'd0; s_pt = 1'b0; s_ir = 1'b0; s_iv = 32'd0;
    s_cv = 1'b0; s_ce = 5'd0; s_cval = 32'd0; s_ctk = 1'b0; s_ctg = 32'd0;
    s_rdy = 1'b1; s_q1 = 5'd0; s_q2 = 5'd0;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] v, input bit tk, input logic [31:0] tg);
    s_cv = 1'b1; s_ce = tag; s_cval = v; s_ctk = tk; s_ctg = tg;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input bit rdy, input logic [31:0] v, input bit pt);
    s_v = 1'b1; s_t = t; s_rd = rd; s_ir = rdy; s_iv = v; s_pt = pt;
  endtask

  task automatic drive();
    bus.issue_valid = s_v; bus.issue_type = s_t; bus.issue_rd = s_rd;
    bus.issue_pred_taken = s_pt; bus.issue_ready = s_ir; bus.issue_val = s_iv;
    bus.cdb_valid = s_cv; bus.cdb_entry = s_ce; bus.cdb_val = s_cval;
    bus.cdb_taken = s_ctk; bus.cdb_target = s_ctg;
    bus.qry_entry1 = s_q1; bus.qry_entry2 = s_q2; rdy_in = s_rdy;
  endtask

  task automatic qchk(input string nm, input logic [4:0] q, input logic ardy, input logic [31:0] aval);
    int k; bit er; logic [31:0] ev;
    k = find(int'(q));
    er = (k >= 0) && rob[k].rdy;
    ev = (k >= 0) ? rob[k].val : 32'd0;
    if (s_cv && (s_ce == q)) begin er = 1'b1; ev = s_cval; end
    chk({nm, "_ready"}, 32'(ardy), 32'(er));
    if (er) chk({nm, "_val"}, aval, ev);
  endtask

  // One cycle: apply stimulus, check combinational outputs, then advance the model past the edge.
  task automatic tick();
    bit full, acc; ent_t e; cexp_t c; int k;
    @(negedge clk_in);
    drive();
    #1;
    full = (rob.size() == 32) || flushing || clear_now;
    acc  = s_rdy && s_v && !full;
    chk("rob_full", 32'(bus.rob_full), 32'(full));
    chk("issue_entry", 32'(bus.issue_entry), 32'(tail));
    chk("rf_issue_rob_entry", 32'(bus.rf_issue_rob_entry), 32'(tail));
    chk("rf_issue_reg_id", 32'(bus.rf_issue_reg_id), (acc && s_t != 2'd1) ? 32'(s_rd) : 32'd0);
    qchk("qry1", s_q1, bus.qry_ready1, bus.qry_val1);
    qchk("qry2", s_q2, bus.qry_ready2, bus.qry_val2);
    if (!s_rdy) begin
      clear_now = 1'b0;
    end else if (flushing) begin
      rob.delete(); tail = 0; flushing = 1'b0; clear_now = 1'b1;
    end else begin
      clear_now = 1'b0;
      if (rob.size() > 0 && rob[0].rdy) begin
        e = rob.pop_front();
        if (e.typ == 2'd1 || e.rd != 5'd0) begin
          c.st = (e.typ == 2'd1); c.rd = c.st ? 5'd0 : e.rd; c.data = e.val; c.tag = 5'(e.tag);
          exp_c.push_back(c);
        end
        if (e.typ == 2'd2 && e.tkn != e.pred) begin flushing = 1'b1; exp_f.push_back(e.tgt); end
      end
      if (s_cv) begin
        k = find(int'(s_ce));
        if (k >= 0) begin rob[k].rdy = 1'b1; rob[k].val = s_cval; rob[k].tkn = s_ctk; rob[k].tgt = s_ctg; end
      end
      if (acc) begin
        e.tag = tail; e.typ = s_t; e.rd = s_rd; e.rdy = s_ir; e.val = s_iv;
        e.pred = s_pt; e.tkn = s_pt; e.tgt = 32'd0;
        rob.push_back(e);
        tail = (tail + 1) % 32;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    mon_en = 1'b0; clr(); drive(); rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    rob.delete(); exp_c.delete(); exp_f.delete();
    tail = 0; flushing = 1'b0; clear_now = 1'b0; mon_en = 1'b1;
    #1;
    chk("rst_commit_reg_id", 32'(bus.rf_commit_reg_id), 32'd0);
    chk("rst_commit_data", bus.rf_commit_data, 32'd0);
    chk("rst_commit_entry", 32'(bus.rf_commit_rob_entry), 32'd0);
    chk("rst_store_commit", 32'(bus.store_commit), 32'd0);
    chk("rst_store_entry", 32'(bus.store_commit_entry), 32'd0);
    chk("rst_clear_up", 32'(bus.rob_clear_up), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_rob_full", 32'(bus.rob_full), 32'd0);
  endtask

  // Resolve every outstanding entry in order until the model buffer is empty.
  task automatic drain();
    int k;
    for (int n = 0; n < 400; n++) begin
      if (rob.size() == 0 && !flushing) break;
      clr();
      k = -1;
      foreach (rob[i]) if (k < 0 && !rob[i].rdy) k = i;
      if (k >= 0) cdb(5'(rob[k].tag), $urandom, rob[k].pred, $urandom);
      tick();
    end
    if (rob.size() != 0 || flushing) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d entries still pending, required 0", rob.size());
    end
    clr(); tick(); tick();
  endtask

  // Retire-side monitor: every visible commit or clear must match the next predicted event.
  always @(negedge clk_in) begin
    cexp_t m;
    if (mon_en) begin
      if (bus.store_commit || bus.rf_commit_reg_id != 5'd0) begin
        if (exp_c.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_commit: got reg %0d store %0d, required no commit",
                   bus.rf_commit_reg_id, bus.store_commit);
        end else begin
          m = exp_c.pop_front();
          chk("commit_is_store", 32'(bus.store_commit), 32'(m.st));
          chk("commit_reg_id", 32'(bus.rf_commit_reg_id), 32'(m.rd));
          if (m.st) chk("store_commit_entry", 32'(bus.store_commit_entry), 32'(m.tag));
          else begin
            chk("commit_data", bus.rf_commit_data, m.data);
            chk("commit_rob_entry", 32'(bus.rf_commit_rob_entry), 32'(m.tag));
          end
        end
      end
      if (bus.rob_clear_up) begin
        if (exp_f.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_clear: got rob_clear_up 1, required 0");
        end else chk("redirect_pc", bus.redirect_pc, exp_f.pop_front());
      end
    end
  end

  initial begin
    int k;
    clr();
    // In-order retirement despite out-of-order writeback.
    do_reset();
    for (int r = 1; r <= 3; r++) begin clr(); issue(2'd0, 5'(r), 1'b0, 32'd0, 1'b0); tick(); end
    clr(); cdb(5'd1, 32'h55, 1'b0, 32'd0); tick();
    clr(); tick(); tick();
    clr(); cdb(5'd0, 32'h11, 1'b0, 32'd0); tick();
    clr(); repeat (4) tick();
    // Fill, overflow attempt, then commit and wrap of the tail.
    do_reset();
    for (int i = 0; i < 33; i++) begin clr(); issue(2'd0, 5'(i % 31 + 1), 1'b0, 32'd0, 1'b0); tick(); end
    clr(); cdb(5'd0, 32'hA0, 1'b0, 32'd0); tick();
    clr(); issue(2'd0, 5'd7, 1'b0, 32'd0, 1'b0); tick();
    clr(); issue(2'd0, 5'd8, 1'b0, 32'd0, 1'b0); tick();
    clr(); issue(2'd0, 5'd9, 1'b0, 32'd0, 1'b0); tick();
    drain();
    // Same-cycle CDB forwarding and a non-busy tag.
    do_reset();
    for (int i = 0; i < 5; i++) begin clr(); issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0); tick(); end
    clr(); cdb(5'd4, 32'hDEAD, 1'b0, 32'd0); s_q1 = 5'd4; s_q2 = 5'd10; tick();
    clr(); s_q1 = 5'd10; s_q2 = 5'd4; tick();
    drain();
    // Store retirement.
    do_reset();
    clr(); issue(2'd1, 5'd9, 1'b0, 32'd0, 1'b0); tick();
    clr(); cdb(5'd0, 32'h77, 1'b0, 32'd0); tick();
    clr(); repeat (3) tick();
    // Mispredicted branch: commit, clear with redirect, issue blocked until C+2.
    do_reset();
    clr(); issue(2'd2, 5'd1, 1'b0, 32'd0, 1'b0); tick();
    clr(); issue(2'd0, 5'd4, 1'b0, 32'd0, 1'b0); tick();
    clr(); issue(2'd0, 5'd5, 1'b1, 32'h5, 1'b0); tick();
    clr(); cdb(5'd0, 32'h24, 1'b1, 32'h1000); tick();
    for (int i = 0; i < 5; i++) begin clr(); issue(2'd0, 5'd6, 1'b0, 32'h0, 1'b0); tick(); end
    drain();
    // Global enable low holds a ready head for three cycles.
    do_reset();
    clr(); issue(2'd0, 5'd5, 1'b1, 32'h99, 1'b0); tick();
    clr(); s_rdy = 1'b0; repeat (3) tick();
    clr(); repeat (3) tick();
    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      clr();
      s_rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1)
        issue(2'($urandom_range(0, 2)), 5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
              $urandom, 1'($urandom_range(0, 1)));
      if (rob.size() > 0 && $urandom_range(0, 9) < 6) begin
        k = $urandom_range(0, rob.size() - 1);
        cdb(5'(rob[k].tag), $urandom, ($urandom_range(0, 7) == 0) ? !rob[k].pred : rob[k].pred, $urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        cdb(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      s_q1 = ($urandom_range(0, 1) == 1) ? s_ce : 5'($urandom_range(0, 31));
      s_q2 = 5'($urandom_range(0, 31));
      tick();
    end
    drain();
    if (exp_c.size() != 0 || exp_f.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL missing_retire: %0d commits and %0d clears never seen, required 0",
               exp_c.size(), exp_f.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
